qpsk_demapper: RTL
==================

QPSK_DEMAPPER -- requirements
Module: qpsk_demapper

Interface
REQ-001 Parameter SAMPLE_W, default 16: width of the signed two's-complement I and Q samples.
REQ-002 Parameter LOW_CONF_THR, default 4096: magnitude threshold for low-confidence counting; used only with the configuration macro.
REQ-003 clk  input  1  single clock; all logic is on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 s_axis_valid  input  1  input symbol valid.
REQ-006 s_axis_ready  output  1  demapper accepts a symbol.
REQ-007 s_axis_i  input  SAMPLE_W  in-phase sample.
REQ-008 s_axis_q  input  SAMPLE_W  quadrature sample.
REQ-009 s_axis_last  input  1  final symbol of a block.
REQ-010 s_axis_sop  input  1  first symbol of a block.
REQ-011 s_axis_is_parity  input  1  sideband tag, carried through.
REQ-012 m_axis_valid  output  1  output byte valid.
REQ-013 m_axis_ready  input  1  downstream accepts the byte.
REQ-014 m_axis_data  output  8  recovered byte.
REQ-015 m_axis_last  output  1  final byte of a block.
REQ-016 m_axis_sop  output  1  first byte of a block.
REQ-017 m_axis_is_parity  output  1  sideband tag.
REQ-018 align_err  output  1  one-cycle pulse when the accumulated byte is discarded on sop.

Function
REQ-019 Hard decision: bit = sign bit (MSB) of the sample; a negative sample gives 1; zero or positive gives 0.
REQ-020 Each symbol yields the dibit {bI, bQ}; symbol k (k = 0..3) of a byte fills m_axis_data[7-2k:6-2k]; the first symbol goes to the MSBs.
REQ-021 A 2-bit symbol counter sym_cnt (0..3) and a 6-bit accumulator track the byte in progress; a handshake is s_axis_valid && s_axis_ready.
REQ-022 s_axis_ready = (sym_cnt != 3 && !s_axis_last) || !m_axis_valid || m_axis_ready.
- The ready path is combinational from m_axis_ready; there are no other combinational in-to-out paths.
REQ-023 A handshake at sym_cnt == 3 loads the full byte into the output register; m_axis_valid rises the next cycle (latency 1 cycle after the 4th symbol).
REQ-024 A handshake with s_axis_last at sym_cnt < 3 flushes a partial byte.
- Unfilled dibits are 0.
- m_axis_last = 1.
- sym_cnt returns to 0.
REQ-025 A handshake with s_axis_sop while sym_cnt != 0:
- discard the accumulated dibits;
- pulse align_err for 1 cycle;
- treat the current symbol as k = 0.
REQ-026 Sideband on each output byte:
- m_axis_sop and m_axis_is_parity are captured from that byte's k = 0 symbol;
- m_axis_last is the OR of s_axis_last over the byte's symbols.
REQ-027 The output register holds data and sideband stable while m_axis_valid && !m_axis_ready.
- m_axis_valid clears on an output handshake unless a new byte loads in the same cycle.
REQ-028 Back-to-back operation: a full byte every 4 cycles with no bubbles when m_axis_ready = 1.

Reset
REQ-029 While rst_n = 0, all outputs are 0, including m_axis_valid, s_axis_ready and align_err.
- Clearing is immediate and needs no clock.
REQ-030 Reset mid-byte or mid-stall discards all state (sym_cnt = 0, accumulator = 0, output register empty); no partial byte is emitted after release.
REQ-031 s_axis_ready is 1 from the first clock edge after rst_n deasserts.

Configuration
REQ-032 With macro QPSK_DEMAPPER_LOWCONF_EN defined, the block adds port low_conf_cnt (output, 32 bits).
- The counter increments on every input handshake where |I| < LOW_CONF_THR or |Q| < LOW_CONF_THR.
- |x| of the most negative value saturates to its positive maximum.
- The counter saturates at 0xFFFFFFFF and resets to 0.
REQ-033 Without QPSK_DEMAPPER_LOWCONF_EN, the port and counter logic are absent; all other behaviour is identical.

Verification
REQ-034 Symbols (-23170,+23170), (-23170,-23170), (+23170,-23170), (+23170,+23170), with sop on the first and last on the fourth -> one byte 0xB4 with sop = 1 and last = 1, valid 1 cycle after the 4th handshake.
REQ-035 A 512-byte random block with randomized valid and ready (ready low 1 cycle in 8) -> 512 bytes matching the source, sop on byte 0 only, last on byte 511 only.
REQ-036 Zero samples (0,0) x4 -> 0x00; samples (-1,-1) x4 -> 0xFF.
REQ-037 Two symbols (-,-), (-,-) followed by a symbol with sop -> align_err pulses once; the next byte is built from the sop symbol onward.
REQ-038 Three symbols (-,+) x3 with last on the third -> byte 0xA8 with last = 1.
REQ-039 rst_n pulsed low while m_axis_valid = 1 and stalled -> m_axis_valid = 0 immediately; with the macro enabled, low_conf_cnt = 0 and counts 2 after symbols (100,30000), (30000,-100).

Source files
------------

// File: rtl/qpsk_demapper.sv
// QPSK hard-decision demapper: packs four {sign(I), sign(Q)} dibits per byte, MSB first, with sop/last/parity sideband.
// Optional low-confidence symbol counter enabled by defining QPSK_DEMAPPER_LOWCONF_EN.
module qpsk_demapper #(
  parameter int SAMPLE_W     = 16,
  parameter int LOW_CONF_THR = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_axis_valid,
  output logic                s_axis_ready,
  input  logic [SAMPLE_W-1:0] s_axis_i,
  input  logic [SAMPLE_W-1:0] s_axis_q,
  input  logic                s_axis_last,
  input  logic                s_axis_sop,
  input  logic                s_axis_is_parity,
  output logic                m_axis_valid,
  input  logic                m_axis_ready,
  output logic [7:0]          m_axis_data,
  output logic                m_axis_last,
  output logic                m_axis_sop,
  output logic                m_axis_is_parity,
  output logic                align_err
`ifdef QPSK_DEMAPPER_LOWCONF_EN
  ,
  output logic [31:0]         low_conf_cnt
`endif
);

  // Byte-in-progress state
  logic [1:0] r_sym_cnt;
  logic [5:0] r_acc;
  logic       r_acc_sop;
  logic       r_acc_par;
  logic       r_acc_last;
  logic       r_run;
  logic       r_align_err;

  // Output register
  logic       r_m_valid;
  logic [7:0] r_m_data;
  logic       r_m_last;
  logic       r_m_sop;
  logic       r_m_par;

  logic       w_hs;
  logic       w_realign;
  logic [1:0] w_k;
  logic [1:0] w_dibit;
  logic [5:0] w_base;
  logic [7:0] w_byte;
  logic       w_first;
  logic       w_sop;
  logic       w_par;
  logic       w_last;
  logic       w_load;

  // r_run keeps ready low during reset and raises it on the first edge after release.
  assign s_axis_ready = r_run &&
                        (((r_sym_cnt != 2'd3) && !s_axis_last) || !r_m_valid || m_axis_ready);

  assign w_hs      = s_axis_valid && s_axis_ready;
  assign w_realign = s_axis_sop && (r_sym_cnt != 2'd0);
  assign w_k       = w_realign ? 2'd0 : r_sym_cnt;
  assign w_dibit   = {s_axis_i[SAMPLE_W-1], s_axis_q[SAMPLE_W-1]};
  assign w_base    = w_realign ? 6'd0 : r_acc;
  assign w_first   = (w_k == 2'd0);
  assign w_sop     = w_first ? s_axis_sop       : r_acc_sop;
  assign w_par     = w_first ? s_axis_is_parity : r_acc_par;
  assign w_last    = s_axis_last || (!w_first && r_acc_last);
  assign w_load    = w_hs && ((w_k == 2'd3) || s_axis_last);

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    w_byte = {w_base, 2'b00};
    case (w_k)
      2'd0:    w_byte[7:6] = w_dibit;
      2'd1:    w_byte[5:4] = w_dibit;
      2'd2:    w_byte[3:2] = w_dibit;
      default: w_byte[1:0] = w_dibit;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run       <= 1'b0;
      r_sym_cnt   <= 2'd0;
      r_acc       <= 6'd0;
      r_acc_sop   <= 1'b0;
      r_acc_par   <= 1'b0;
      r_acc_last  <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      r_run       <= 1'b1;
      r_align_err <= w_hs && w_realign;
      if (w_hs) begin
        if (w_load) begin
          r_sym_cnt  <= 2'd0;
          r_acc      <= 6'd0;
          r_acc_sop  <= 1'b0;
          r_acc_par  <= 1'b0;
          r_acc_last <= 1'b0;
        end else begin
          r_sym_cnt  <= w_k + 2'd1;
          r_acc      <= w_byte[7:2];
          r_acc_sop  <= w_sop;
          r_acc_par  <= w_par;
          r_acc_last <= w_last;
        end
      end
    end
  end

  // A new byte may load in the same cycle the previous one is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_data  <= 8'd0;
      r_m_last  <= 1'b0;
      r_m_sop   <= 1'b0;
      r_m_par   <= 1'b0;
    end else if (w_load) begin
      r_m_valid <= 1'b1;
      r_m_data  <= w_byte;
      r_m_last  <= w_last;
      r_m_sop   <= w_sop;
      r_m_par   <= w_par;
    end else if (m_axis_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign m_axis_valid     = r_m_valid;
  assign m_axis_data      = r_m_data;
  assign m_axis_last      = r_m_last;
  assign m_axis_sop       = r_m_sop;
  assign m_axis_is_parity = r_m_par;
  assign align_err        = r_align_err;

`ifdef QPSK_DEMAPPER_LOWCONF_EN
  localparam logic [SAMPLE_W:0] LowThr = (SAMPLE_W+1)'(LOW_CONF_THR);

  // The most negative sample has no positive twin, so it maps to the positive maximum.
  function automatic logic [SAMPLE_W-1:0] sat_abs(input logic [SAMPLE_W-1:0] x);
    if (x == {1'b1, {(SAMPLE_W-1){1'b0}}})
      return {1'b0, {(SAMPLE_W-1){1'b1}}};
    else if (x[SAMPLE_W-1])
      return (~x) + 1'b1;
    else
      return x;
  endfunction

  logic [31:0] r_low_conf_cnt;
  logic        w_low;

  assign w_low = ({1'b0, sat_abs(s_axis_i)} < LowThr) ||
                 ({1'b0, sat_abs(s_axis_q)} < LowThr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_low_conf_cnt <= 32'd0;
    else if (w_hs && w_low && (r_low_conf_cnt != 32'hFFFF_FFFF))
      r_low_conf_cnt <= r_low_conf_cnt + 32'd1;
  end

  assign low_conf_cnt = r_low_conf_cnt;
`else
  // Only the sign bits matter for the hard decision itself.
  logic w_unused_bits;
  assign w_unused_bits = ^{s_axis_i[SAMPLE_W-2:0], s_axis_q[SAMPLE_W-2:0], LOW_CONF_THR[0]};
`endif

endmodule
